// File: rtl/tdc_calib_seq.sv
// tdc_calib_seq
//   Calibration sequencer for the two-channel time tagger. Each run gates the
//   calibration ring oscillator on, lets it settle, steers both TDC channels
//   onto the calibration clock and counts hits per channel. A run ends when
//   both channels reach the hit target, the timeout expires or abort_i is
//   raised. The channels then go back to their signal inputs, and the
//   oscillator keeps running for a short guard period. Runs start on start_i
//   or periodically from IDLE.
//
// Ports
//   clk_i, reset_n_i        system clock, async active-low reset
//   start_i, abort_i        run request (pulse) / early termination (level)
//   auto_en_i, period_i     periodic recalibration enable and interval
//   hits_target_i           hits required per channel (latched per run)
//   timeout_i               CALIB cycle limit, 0 = none (latched per run)
//   hit_i[1:0]              per-channel hit strobes
//   osc_en_o, calib_sel_o   ring-oscillator enable, per-channel input mux
//   busy_o, done_o          not-IDLE flag, end-of-run pulse
//   timeout_o               sticky: last run ended by timeout or abort
//   hit_cnt0_o, hit_cnt1_o  per-channel hit counts
//   state_o                 IDLE=0 SETTLE=1 CALIB=2 GUARD=3 DONE=4

// Per-channel saturating hit counter. full_nxt_o looks one edge ahead, so the
// sequencer can drop the channel's calib_sel bit on the edge that fills it.
module tdc_calib_chan #(
    parameter int g_HITS_W = 16
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                hit_i,
    input  logic [g_HITS_W-1:0] target_i,
    output logic [g_HITS_W-1:0] cnt_o,
    output logic                full_nxt_o
);
    logic [g_HITS_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_o;
        if (clr_i)
            cnt_nxt = '0;
        else if (en_i && hit_i && (cnt_o < target_i))
            cnt_nxt = cnt_o + g_HITS_W'(1);
    end

    assign full_nxt_o = (cnt_nxt >= target_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_o <= '0;
        else            cnt_o <= cnt_nxt;
    end
endmodule

module tdc_calib_seq #(
    parameter int g_SETTLE_CYCLES = 1024,
    parameter int g_GUARD_CYCLES  = 16,
    parameter int g_HITS_W        = 16,
    parameter int g_TIMEOUT_W     = 24,
    parameter int g_PERIOD_W      = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   auto_en_i,
    input  logic [g_PERIOD_W-1:0]  period_i,
    input  logic [g_HITS_W-1:0]    hits_target_i,
    input  logic [g_TIMEOUT_W-1:0] timeout_i,
    input  logic [1:0]             hit_i,
    output logic                   osc_en_o,
    output logic [1:0]             calib_sel_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [g_HITS_W-1:0]    hit_cnt0_o,
    output logic [g_HITS_W-1:0]    hit_cnt1_o,
    output logic [2:0]             state_o
);
    localparam int NUM_CH  = 2;
    localparam int DLY_MAX = (g_SETTLE_CYCLES > g_GUARD_CYCLES) ? g_SETTLE_CYCLES : g_GUARD_CYCLES;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam logic [DLY_W-1:0] SETTLE_LAST = DLY_W'(g_SETTLE_CYCLES - 1);
    localparam logic [DLY_W-1:0] GUARD_LAST  = DLY_W'(g_GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CALIB  = 3'd2,
        ST_GUARD  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t st_q, st_nxt;

    logic [DLY_W-1:0]                  dly_q;
    logic [g_TIMEOUT_W-1:0]            tmo_q, tmo_lat_q;
    logic [g_PERIOD_W-1:0]             per_q;
    logic [g_HITS_W-1:0]               tgt_q;
    logic [NUM_CH-1:0][g_HITS_W-1:0]   cnt_q;
    logic [NUM_CH-1:0]                 full_nxt;

    logic per_run, per_trig, trig, tmo_exp, all_full, early_end;
    logic osc_en_d, busy_d, done_d, tmo_flag_d;
    logic [1:0] calib_sel_d;

    // Period counter only advances in IDLE; trigger compares with >= so a
    // period lowered below the running count still fires instead of wrapping.
    assign per_run  = auto_en_i && (period_i != '0);
    assign per_trig = per_run && (per_q >= period_i - g_PERIOD_W'(1));
    // start_i paired with abort_i is dropped; periodic triggers are not.
    assign trig     = (st_q == ST_IDLE) && ((start_i && !abort_i) || per_trig);
    assign tmo_exp  = (tmo_lat_q != '0) && (tmo_q == tmo_lat_q - g_TIMEOUT_W'(1));
    assign all_full = &full_nxt;
    // Completion on the same edge outranks timeout/abort.
    assign early_end = ((st_q == ST_SETTLE) && abort_i) ||
                       ((st_q == ST_CALIB) && !all_full && (abort_i || tmo_exp));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tdc_calib_chan #(.g_HITS_W(g_HITS_W)) u_chan (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .clr_i      (trig),
            .en_i       (st_q == ST_CALIB),
            .hit_i      (hit_i[k]),
            .target_i   (tgt_q),
            .cnt_o      (cnt_q[k]),
            .full_nxt_o (full_nxt[k])
        );
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) st_q <= ST_IDLE;
        else            st_q <= st_nxt;
    end

    // Next-state logic
    always_comb begin
        st_nxt = st_q;
        case (st_q)
            ST_IDLE:   if (trig) st_nxt = ST_SETTLE;
            ST_SETTLE: if (abort_i) st_nxt = ST_GUARD;
                       else if (dly_q == SETTLE_LAST) st_nxt = ST_CALIB;
            ST_CALIB:  if (all_full || early_end) st_nxt = ST_GUARD;
            ST_GUARD:  if (dly_q == GUARD_LAST) st_nxt = ST_DONE;
            ST_DONE:   st_nxt = ST_IDLE;
            default:   st_nxt = ST_IDLE;
        endcase
    end

    // Output logic, computed from the next state and registered below so
    // every output changes on the same edge as the state.
    always_comb begin
        osc_en_d    = (st_nxt == ST_SETTLE) || (st_nxt == ST_CALIB) || (st_nxt == ST_GUARD);
        busy_d      = (st_nxt != ST_IDLE);
        done_d      = (st_nxt == ST_DONE);
        calib_sel_d = (st_nxt == ST_CALIB) ? ~full_nxt : 2'b00;
        tmo_flag_d  = timeout_o;
        if (trig)           tmo_flag_d = 1'b0;
        else if (early_end) tmo_flag_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            osc_en_o    <= 1'b0;
            calib_sel_o <= 2'b00;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            osc_en_o    <= osc_en_d;
            calib_sel_o <= calib_sel_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            timeout_o   <= tmo_flag_d;
        end
    end

    // Phase/period/timeout counters and per-run latches
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dly_q     <= '0;
            tmo_q     <= '0;
            per_q     <= '0;
            tgt_q     <= '0;
            tmo_lat_q <= '0;
        end else begin
            if (st_nxt != st_q)
                dly_q <= '0;
            else if ((st_q == ST_SETTLE) || (st_q == ST_GUARD))
                dly_q <= dly_q + DLY_W'(1);

            if (trig)
                tmo_q <= '0;
            else if (st_q == ST_CALIB)
                tmo_q <= tmo_q + g_TIMEOUT_W'(1);

            if ((st_q == ST_IDLE) && per_run && !trig)
                per_q <= per_q + g_PERIOD_W'(1);
            else
                per_q <= '0;

            if (trig) begin
                tgt_q     <= hits_target_i;
                tmo_lat_q <= timeout_i;
            end
        end
    end

    assign hit_cnt0_o = cnt_q[0];
    assign hit_cnt1_o = cnt_q[1];
    assign state_o    = st_q;
endmodule

// File: tb/tb_tdc_calib_seq.sv
// Testbench for tdc_calib_seq (SETTLE=4, GUARD=2). A behavioural model tracks
// the run phase, time spent in it and per-channel hit counts, and predicts the
// full output vector after every clock edge.
module tb_tdc_calib_seq;
    localparam int SETTLE = 4;
    localparam int GUARD  = 2;

    logic        clk, rst_n, start, abort, auto_en;
    logic [31:0] period;
    logic [15:0] hits_target;
    logic [23:0] tmo_lim;
    logic [1:0]  hit;
    logic        osc_en, busy, done, tmo_o;
    logic [1:0]  calib_sel;
    logic [15:0] cnt0, cnt1;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    tdc_calib_seq #(.g_SETTLE_CYCLES(SETTLE), .g_GUARD_CYCLES(GUARD)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .abort_i(abort),
        .auto_en_i(auto_en), .period_i(period), .hits_target_i(hits_target),
        .timeout_i(tmo_lim), .hit_i(hit), .osc_en_o(osc_en), .calib_sel_o(calib_sel),
        .busy_o(busy), .done_o(done), .timeout_o(tmo_o), .hit_cnt0_o(cnt0),
        .hit_cnt1_o(cnt1), .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [40:0] dut_v;
    assign dut_v = {osc_en, calib_sel, busy, done, tmo_o, state, cnt0, cnt1};

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 oscillator settling, 2 counting, 3 guard, 4 done
    int phase, age, idle_run, tgt, tlim;
    int mcnt[2];
    bit mflag;

    task automatic model_reset();
        phase = 0; age = 0; idle_run = 0; tgt = 0; tlim = 0;
        mcnt[0] = 0; mcnt[1] = 0; mflag = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit auto_on;
        nxt = phase;
        auto_on = auto_en && (period != 0);
        case (phase)
            0: if ((start && !abort) || (auto_on && idle_run == int'(period) - 1)) begin
                   nxt = 1; tgt = int'(hits_target); tlim = int'(tmo_lim);
                   mcnt[0] = 0; mcnt[1] = 0; mflag = 0;
               end
            1: if (abort) begin nxt = 3; mflag = 1; end
               else if (age + 1 == SETTLE) nxt = 2;
            2: begin
                   for (int k = 0; k < 2; k++)
                       if (hit[k] && mcnt[k] < tgt) mcnt[k]++;
                   if (mcnt[0] >= tgt && mcnt[1] >= tgt) nxt = 3;
                   else if (abort || (tlim != 0 && age + 1 == tlim)) begin nxt = 3; mflag = 1; end
               end
            3: if (age + 1 == GUARD) nxt = 4;
            default: nxt = 0;
        endcase
        idle_run = (phase == 0 && nxt == 0 && auto_on) ? idle_run + 1 : 0;
        age      = (nxt == phase) ? age + 1 : 0;
        phase    = nxt;
    endtask

    function automatic logic [40:0] exp_v();
        logic [1:0] sel;
        sel = 2'b00;
        if (phase == 2) sel = {mcnt[1] < tgt, mcnt[0] < tgt};
        return {(phase >= 1 && phase <= 3), sel, phase != 0, phase == 4, mflag,
                3'(phase), 16'(mcnt[0]), 16'(mcnt[1])};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
        cyc++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; hit = 2'b11; hits_target = 16'd3;
        repeat (3) tick();
        checks++;
        if (dut_v !== 41'd0) begin errors++; $display("FAIL reset_hold got=%h want=0", dut_v); end
        start = 1'b0; hit = 2'b00;
        rst_n = 1'b1;
        tick();
        checks++;
        if (dut_v !== 41'd0) begin errors++; $display("FAIL reset_release got=%h want=0", dut_v); end
    endtask

    task automatic test_basic();
        int dn;
        dn = 0; hits_target = 16'd3; tmo_lim = 24'd0;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (osc_en !== 1'b1 || state !== 3'd1) begin errors++; $display("FAIL basic_osc_latency osc=%b st=%0d want osc=1 st=1", osc_en, state); end
        for (int i = 0; i < SETTLE; i++) begin hit = 2'($urandom); tick(); end
        hit = 2'b00;
        checks++;
        if (calib_sel !== 2'b11 || state !== 3'd2 || cnt0 !== 16'd0) begin errors++; $display("FAIL basic_calib_entry sel=%b st=%0d c0=%0d want 11/2/0", calib_sel, state, cnt0); end
        for (int i = 0; i < 300 && busy; i++) begin
            hit = 2'($urandom);
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL basic_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
            dn += int'(done);
        end
        hit = 2'b00;
        checks++;
        if (busy !== 1'b0 || dn !== 1 || cnt0 !== 16'd3 || cnt1 !== 16'd3 || tmo_o !== 1'b0) begin
            errors++; $display("FAIL basic_end busy=%b done_pulses=%0d c=%0d/%0d tmo=%b want 0/1/3/3/0", busy, dn, cnt0, cnt1, tmo_o);
        end
    endtask

    task automatic test_uneven();
        hits_target = 16'd2; tmo_lim = 24'd0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (SETTLE) tick();
        hit = 2'b01; tick(); hit = 2'b00; tick(); hit = 2'b01; tick();
        checks++;
        if (calib_sel !== 2'b10 || cnt0 !== 16'd2) begin errors++; $display("FAIL uneven_ch0_done sel=%b c0=%0d want 10/2", calib_sel, cnt0); end
        hit = 2'b01; repeat (3) tick();
        checks++;
        if (calib_sel !== 2'b10 || cnt0 !== 16'd2 || state !== 3'd2) begin errors++; $display("FAIL uneven_saturate sel=%b c0=%0d st=%0d want 10/2/2", calib_sel, cnt0, state); end
        hit = 2'b10; tick(); hit = 2'b00; tick(); hit = 2'b10; tick(); hit = 2'b00;
        checks++;
        if (calib_sel !== 2'b00 || state !== 3'd3 || cnt1 !== 16'd2 || osc_en !== 1'b1) begin
            errors++; $display("FAIL uneven_ch1_done sel=%b st=%0d c1=%0d osc=%b want 00/3/2/1", calib_sel, state, cnt1, osc_en);
        end
        for (int i = 0; i < 50 && busy; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL uneven_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
        end
    endtask

    task automatic test_timeout();
        int ncal, dn;
        ncal = 0; dn = 0; hits_target = 16'd5; tmo_lim = 24'd20;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 300 && busy; i++) begin
            hit = (state == 3'd2 && ncal == 3) ? 2'b10 : 2'b00;
            tick();
            ncal += int'(state == 3'd2);
            dn += int'(done);
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL timeout_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
        end
        hit = 2'b00;
        checks++;
        if (ncal !== 20 || tmo_o !== 1'b1 || cnt0 !== 16'd0 || cnt1 !== 16'd1 || dn !== 1) begin
            errors++; $display("FAIL timeout_end calib_cycles=%0d tmo=%b c=%0d/%0d done=%0d want 20/1/0/1/1", ncal, tmo_o, cnt0, cnt1, dn);
        end
    endtask

    task automatic test_abort_settle();
        int sel_seen, dn;
        sel_seen = 0; dn = 0; hits_target = 16'd2; tmo_lim = 24'd0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (state !== 3'd3 || tmo_o !== 1'b1 || osc_en !== 1'b1) begin errors++; $display("FAIL abort_to_guard st=%0d tmo=%b osc=%b want 3/1/1", state, tmo_o, osc_en); end
        for (int i = 0; i < 50 && busy; i++) begin
            tick();
            sel_seen += int'(calib_sel != 2'b00);
            dn += int'(done);
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL abort_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
        end
        checks++;
        if (sel_seen !== 0 || dn !== 1 || tmo_o !== 1'b1) begin errors++; $display("FAIL abort_end sel_cycles=%0d done=%0d tmo=%b want 0/1/1", sel_seen, dn, tmo_o); end
    endtask

    task automatic test_busy_start();
        int busy_cnt;
        busy_cnt = 0; hits_target = 16'd1; tmo_lim = 24'd0;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL start_abort_idle busy=%b st=%0d want 0/0", busy, state); end
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 100 && busy; i++) begin
            start = ($urandom_range(0, 2) == 0) && (state != 3'd4);
            hit = 2'($urandom);
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL busy_start_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
        end
        start = 1'b0; hit = 2'b00;
        repeat (10) begin tick(); busy_cnt += int'(busy); end
        checks++;
        if (busy_cnt !== 0) begin errors++; $display("FAIL busy_start_queued busy_cycles=%0d want 0", busy_cnt); end
    endtask

    task automatic test_target0();
        int ncal;
        ncal = 0; hits_target = 16'd0; tmo_lim = 24'd0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 50 && busy; i++) begin
            hit = 2'($urandom);
            tick();
            ncal += int'(state == 3'd2);
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL target0_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
        end
        hit = 2'b00;
        checks++;
        if (ncal !== 1 || cnt0 !== 16'd0 || cnt1 !== 16'd0 || tmo_o !== 1'b0) begin
            errors++; $display("FAIL target0_end calib_cycles=%0d c=%0d/%0d tmo=%b want 1/0/0/0", ncal, cnt0, cnt1, tmo_o);
        end
    endtask

    task automatic test_auto();
        int idle_len, gaps, busy_cnt;
        bit prev_busy, seen_run;
        idle_len = 0; gaps = 0; busy_cnt = 0; seen_run = 0;
        hits_target = 16'd2; tmo_lim = 24'd0; period = 32'd50; auto_en = 1'b1;
        prev_busy = busy;
        for (int i = 0; i < 400; i++) begin
            hit = 2'($urandom);
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL auto_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
            if (!busy) begin
                if (prev_busy) begin seen_run = 1; idle_len = 0; end
                idle_len++;
            end else if (!prev_busy && seen_run) begin
                gaps++;
                checks++;
                if (idle_len !== 50) begin errors++; $display("FAIL auto_gap idle_cycles=%0d want 50", idle_len); end
            end
            prev_busy = busy;
        end
        checks++;
        if (gaps < 2) begin errors++; $display("FAIL auto_runs gaps=%0d want >=2", gaps); end
        period = 32'd0;
        for (int i = 0; i < 100 && busy; i++) tick();
        hit = 2'b00;
        repeat (120) begin tick(); busy_cnt += int'(busy); end
        checks++;
        if (busy_cnt !== 0) begin errors++; $display("FAIL auto_period0 busy_cycles=%0d want 0", busy_cnt); end
        auto_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        hits_target = 16'd4; tmo_lim = 24'd0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (SETTLE + 1) tick();
        checks++;
        if (state !== 3'd2 || calib_sel !== 2'b11) begin errors++; $display("FAIL rstmid_pre st=%0d sel=%b want 2/11", state, calib_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_v !== 41'd0) begin errors++; $display("FAIL rstmid_async got=%h want=0", dut_v); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (dut_v !== exp_v() || state !== 3'd0) begin errors++; $display("FAIL rstmid_after got=%h want=%h", dut_v, exp_v()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if (!busy) begin
                hits_target = 16'($urandom_range(0, 4));
                tmo_lim = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom_range(3, 25));
            end
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            hit = 2'($urandom);
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL random_trace t=%0d got=%h want=%h", cyc, dut_v, exp_v()); end
            checks++;
            if (calib_sel != 2'b00 && (!osc_en || state !== 3'd2)) begin
                errors++; $display("FAIL sel_invariant sel=%b osc=%b st=%0d", calib_sel, osc_en, state);
            end
        end
        start = 1'b0; abort = 1'b0; hit = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; auto_en = 1'b0;
        period = 32'd0; hits_target = 16'd0; tmo_lim = 24'd0; hit = 2'b00;
        model_reset();
        test_reset();
        test_basic();
        test_uneven();
        test_timeout();
        test_abort_settle();
        test_busy_start();
        test_target0();
        test_auto();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
